line_fetch_buffer: RTL and testbench

- Upstream feeder for the processing wrapper: accepts a raster pixel stream from the DDR read path and buffers one full line at a time in a ping-pong pair of line banks.
- When a line is complete it pulses READ_LINE_DONE with READ_POSY, then serves that line first-word-fall-through on IN_DATA, advancing one word per IN_DE.
- Filling of the next line overlaps draining of the current one.

---
 rtl/line_fetch_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_line_fetch_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_fetch_buffer.sv
// line_fetch_buffer: ping-pong line buffer between the DDR read path and the
// processing wrapper. One bank fills from the raster stream while the other
// is announced (READ_LINE_DONE / READ_POSY) and drained first-word-fall-through.
module line_fetch_buffer #(
    parameter int WIDTH  = 1600,
    parameter int HEIGHT = 1200,
    parameter int AW     = 11
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        S_VALID,
    output logic        S_READY,
    input  logic [31:0] S_DATA,
    input  logic        S_SOF,
    output logic        READ_LINE_DONE,
    output logic [11:0] READ_POSY,
    input  logic        IN_DE,
    output logic [31:0] IN_DATA,
    output logic [1:0]  ERR
);

    typedef enum logic [1:0] {
        RD_IDLE     = 2'd0,
        RD_ANNOUNCE = 2'd1,
        RD_DRAIN    = 2'd2
    } rd_state_t;

    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_LAST = AW'(WIDTH - 1);
    localparam logic [11:0]   TAG_LAST  = 12'(HEIGHT - 1);

    // Line storage; deliberately not reset so it maps onto block RAM.
    logic [31:0] mem0_r [WIDTH];
    logic [31:0] mem1_r [WIDTH];

    rd_state_t   rd_state_r, rd_state_nxt_s;
    logic [1:0]  bank_full_r, full_nxt_s;
    logic [11:0] bank_tag_r [2];
    logic        wbank_r, wbank_nxt_s;
    logic        rbank_r, rbank_nxt_s;
    logic [AW-1:0] wptr_r, wptr_nxt_s;
    logic [AW-1:0] rptr_r, rptr_nxt_s;
    logic [11:0] line_tag_r, line_tag_nxt_s, cur_tag_s;
    logic        s_ready_r, done_r;
    logic [11:0] posy_r;
    logic [31:0] in_data_r, rd_data_s;
    logic [1:0]  err_r;

    logic          accept_s, fill_s, sof_err_s;
    logic [AW-1:0] wr_addr_s, rd_addr_s;
    logic          rd_en_s, free_s, de_err_s, enter_announce_s;

    // Write side: address, line tag and bank-fill decisions for an accepted pixel.
    always_comb begin
        accept_s       = S_VALID & s_ready_r;
        wr_addr_s      = S_SOF ? ADDR_ZERO : wptr_r;
        cur_tag_s      = S_SOF ? 12'd0 : line_tag_r;
        wptr_nxt_s     = wptr_r;
        wbank_nxt_s    = wbank_r;
        line_tag_nxt_s = line_tag_r;
        fill_s         = 1'b0;
        sof_err_s      = 1'b0;
        if (accept_s) begin
            if (S_SOF && (wptr_r != ADDR_ZERO)) begin
                // Misaligned frame start: drop the partial line, restart at word 0.
                sof_err_s      = 1'b1;
                wptr_nxt_s     = ADDR_ONE;
                line_tag_nxt_s = 12'd0;
            end else if (wptr_r == ADDR_LAST) begin
                fill_s         = 1'b1;
                wptr_nxt_s     = ADDR_ZERO;
                wbank_nxt_s    = ~wbank_r;
                line_tag_nxt_s = (cur_tag_s == TAG_LAST) ? 12'd0 : (cur_tag_s + 12'd1);
            end else begin
                wptr_nxt_s     = wptr_r + ADDR_ONE;
                line_tag_nxt_s = cur_tag_s;
            end
        end else begin
            wptr_nxt_s = wptr_r;
        end
    end

    // Read FSM: announce a full bank, then pop one word per IN_DE until the line ends.
    always_comb begin
        rd_state_nxt_s   = rd_state_r;
        rptr_nxt_s       = rptr_r;
        rbank_nxt_s      = rbank_r;
        rd_en_s          = 1'b0;
        rd_addr_s        = rptr_r;
        free_s           = 1'b0;
        de_err_s         = 1'b0;
        enter_announce_s = 1'b0;
        case (rd_state_r)
            RD_IDLE: begin
                de_err_s = IN_DE;
                if (bank_full_r[rbank_r]) begin
                    // Prefetch word 0 so IN_DATA is valid during the announce cycle.
                    rd_state_nxt_s   = RD_ANNOUNCE;
                    enter_announce_s = 1'b1;
                    rd_en_s          = 1'b1;
                    rd_addr_s        = ADDR_ZERO;
                end else begin
                    rd_state_nxt_s = RD_IDLE;
                end
            end
            RD_ANNOUNCE: begin
                de_err_s       = IN_DE;
                rd_state_nxt_s = RD_DRAIN;
            end
            RD_DRAIN: begin
                if (IN_DE) begin
                    if (rptr_r == ADDR_LAST) begin
                        free_s         = 1'b1;
                        rptr_nxt_s     = ADDR_ZERO;
                        rbank_nxt_s    = ~rbank_r;
                        rd_state_nxt_s = RD_IDLE;
                    end else begin
                        rptr_nxt_s = rptr_r + ADDR_ONE;
                        rd_en_s    = 1'b1;
                        rd_addr_s  = rptr_r + ADDR_ONE;
                    end
                end else begin
                    rd_state_nxt_s = RD_DRAIN;
                end
            end
            default: begin
                rd_state_nxt_s = RD_IDLE;
            end
        endcase
    end

    // Bank occupancy: fill and free may land together but always on different banks.
    always_comb begin
        full_nxt_s = bank_full_r;
        if (fill_s) begin
            full_nxt_s[wbank_r] = 1'b1;
        end else begin
            full_nxt_s[wbank_r] = bank_full_r[wbank_r];
        end
        if (free_s) begin
            full_nxt_s[rbank_r] = 1'b0;
        end else begin
            full_nxt_s[rbank_r] = full_nxt_s[rbank_r];
        end
    end

    // Registered bank read feeding the selected word.
    always_comb begin
        if (rbank_r) begin
            rd_data_s = mem1_r[rd_addr_s];
        end else begin
            rd_data_s = mem0_r[rd_addr_s];
        end
    end

    // Pixel write into the bank currently being filled.
    always_ff @(posedge CLK) begin
        if (accept_s && wbank_r) begin
            mem1_r[wr_addr_s] <= S_DATA;
        end
        if (accept_s && !wbank_r) begin
            mem0_r[wr_addr_s] <= S_DATA;
        end
    end

    // Control state and all registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_state_r    <= RD_IDLE;
            bank_full_r   <= 2'b00;
            bank_tag_r[0] <= 12'd0;
            bank_tag_r[1] <= 12'd0;
            wbank_r       <= 1'b0;
            rbank_r       <= 1'b0;
            wptr_r        <= ADDR_ZERO;
            rptr_r        <= ADDR_ZERO;
            line_tag_r    <= 12'd0;
            s_ready_r     <= 1'b0;
            done_r        <= 1'b0;
            posy_r        <= 12'd0;
            in_data_r     <= 32'd0;
            err_r         <= 2'b00;
        end else begin
            rd_state_r  <= rd_state_nxt_s;
            bank_full_r <= full_nxt_s;
            wbank_r     <= wbank_nxt_s;
            rbank_r     <= rbank_nxt_s;
            wptr_r      <= wptr_nxt_s;
            rptr_r      <= rptr_nxt_s;
            line_tag_r  <= line_tag_nxt_s;
            s_ready_r   <= ~full_nxt_s[wbank_nxt_s];
            done_r      <= enter_announce_s;
            err_r       <= err_r | {sof_err_s, de_err_s};
            if (fill_s) begin
                bank_tag_r[wbank_r] <= cur_tag_s;
            end
            if (enter_announce_s) begin
                posy_r <= bank_tag_r[rbank_r];
            end
            if (rd_en_s) begin
                in_data_r <= rd_data_s;
            end
        end
    end

    assign S_READY        = s_ready_r;
    assign READ_LINE_DONE = done_r;
    assign READ_POSY      = posy_r;
    assign IN_DATA        = in_data_r;
    assign ERR            = err_r;

endmodule

// File: tb/tb_line_fetch_buffer.sv
// Directed bench for line_fetch_buffer: fill/announce/drain, back-pressure,
// tag wrap, misaligned start of frame and asynchronous reset mid-drain.
module tb_line_fetch_buffer;

    localparam int W = 1600;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        S_VALID = 1'b0;
    logic        S_READY;
    logic [31:0] S_DATA = 32'd0;
    logic        S_SOF = 1'b0;
    logic        READ_LINE_DONE;
    logic [11:0] READ_POSY;
    logic        IN_DE = 1'b0;
    logic [31:0] IN_DATA;
    logic [1:0]  ERR;

    int n_err = 0;
    int n_chk = 0;
    int done_cnt = 0;
    bit stalled = 1'b0;
    logic [11:0] posy_q [$];

    line_fetch_buffer #(.WIDTH(W), .HEIGHT(4), .AW(11)) dut (
        .CLK(CLK), .RST_N(RST_N), .S_VALID(S_VALID), .S_READY(S_READY),
        .S_DATA(S_DATA), .S_SOF(S_SOF), .READ_LINE_DONE(READ_LINE_DONE),
        .READ_POSY(READ_POSY), .IN_DE(IN_DE), .IN_DATA(IN_DATA), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Record every announce pulse and its line tag.
    always @(negedge CLK) begin
        if (READ_LINE_DONE) begin
            done_cnt++;
            posy_q.push_back(READ_POSY);
        end
    end

    // Hard stop if something wedges beyond all per-wait bounds.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time exceeded, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_posy(input int idx, input logic [11:0] exp);
        if (posy_q.size() > idx) chk($sformatf("posy[%0d]", idx), posy_q[idx], exp);
        else chk($sformatf("posy_missing[%0d]", idx), posy_q.size(), idx + 1);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_s_ready"}, S_READY, 1'b0);
        chk({pfx, "_done"}, READ_LINE_DONE, 1'b0);
        chk({pfx, "_posy"}, READ_POSY, 12'd0);
        chk({pfx, "_in_data"}, IN_DATA, 32'd0);
        chk({pfx, "_err"}, ERR, 2'b00);
    endtask

    // Present one pixel for exactly one accepting edge; called at a negedge.
    task automatic push(input logic [31:0] d, input logic sof);
        int w = 0;
        while (!S_READY && !stalled && w < 20000) begin
            @(negedge CLK);
            w++;
        end
        if (!S_READY && !stalled) begin
            stalled = 1'b1;
            chk("push_ready_timeout", S_READY, 1'b1);
        end
        S_VALID = 1'b1;
        S_DATA  = d;
        S_SOF   = sof;
        @(negedge CLK);
        S_VALID = 1'b0;
        S_SOF   = 1'b0;
    endtask

    task automatic push_line(input logic [31:0] base, input logic sof);
        for (int i = 0; i < W; i++) push(base + 32'(i), sof && (i == 0));
    endtask

    // Wait until announce number idx (0-based) has been seen, then one more cycle.
    task automatic wait_announce(input int idx);
        int w = 0;
        while (done_cnt <= idx && !stalled && w < 20000) begin
            @(negedge CLK);
            w++;
        end
        if (done_cnt <= idx) begin
            stalled = 1'b1;
            chk($sformatf("announce_timeout[%0d]", idx), done_cnt, idx + 1);
        end
        @(negedge CLK);
    endtask

    // Hold IN_DE high for n pops, checking each word before it is popped.
    task automatic pop_words(input logic [31:0] base, input int n);
        IN_DE = 1'b1;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("in_data[%08h+%0d]", base, k), IN_DATA, base + 32'(k));
            @(negedge CLK);
        end
        IN_DE = 1'b0;
    endtask

    initial begin
        // Reset state
        #1 RST_N = 1'b0;
        #2 chk_reset_outputs("reset");
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("ready_after_reset", S_READY, 1'b1);

        // One line with consumer idle: single announce, tag 0, FWFT word 0
        push_line(32'd0, 1'b1);
        begin
            int w = 0;
            while (!READ_LINE_DONE && w < 20) begin
                @(negedge CLK);
                w++;
            end
        end
        chk("l0_done_seen", READ_LINE_DONE, 1'b1);
        chk("l0_posy", READ_POSY, 12'd0);
        chk("l0_ready_other_empty", S_READY, 1'b1);
        @(negedge CLK);
        chk("l0_first_word", IN_DATA, 32'd0);
        chk("l0_done_one_cycle", READ_LINE_DONE, 1'b0);
        @(negedge CLK);
        pop_words(32'd0, W);
        repeat (5) @(negedge CLK);
        chk("l0_one_pulse", done_cnt, 1);
        chk("l0_err_clean", ERR, 2'b00);

        // Three lines with stalled consumer: back-pressure, then release
        push_line(32'h0001_0000, 1'b1);
        push_line(32'h0002_0000, 1'b0);
        chk("both_full_ready_low", S_READY, 1'b0);
        chk("both_full_one_announced", done_cnt, 2);
        wait_announce(1);
        pop_words(32'h0001_0000, W);
        chk("ready_after_free", S_READY, 1'b1);
        push_line(32'h0003_0000, 1'b0);
        wait_announce(2);
        pop_words(32'h0002_0000, W);
        wait_announce(3);
        pop_words(32'h0003_0000, W);
        chk_posy(1, 12'd0);
        chk_posy(2, 12'd1);
        chk_posy(3, 12'd2);

        // Tag wrap at HEIGHT=4 with overlapped fill and drain
        fork
            begin
                for (int l = 0; l < 5; l++)
                    push_line(32'h0004_0000 + 32'(l) * 32'h1000, l == 0);
            end
            begin
                for (int m = 0; m < 5; m++) begin
                    wait_announce(4 + m);
                    pop_words(32'h0004_0000 + 32'(m) * 32'h1000, W);
                end
            end
        join
        chk_posy(4, 12'd0);
        chk_posy(5, 12'd1);
        chk_posy(6, 12'd2);
        chk_posy(7, 12'd3);
        chk_posy(8, 12'd0);
        push_line(32'h0009_0000, 1'b1);
        wait_announce(9);
        pop_words(32'h0009_0000, W);
        chk_posy(9, 12'd0);
        chk("aligned_sof_no_err", ERR, 2'b00);

        // Start of frame at pixel 700: partial line dropped, restart at word 0
        for (int i = 0; i < 700; i++) push(32'h000A_0000 + 32'(i), 1'b0);
        push(32'h000B_0000, 1'b1);
        chk("misaligned_sof_err", ERR, 2'b10);
        for (int i = 1; i < W; i++) push(32'h000B_0000 + 32'(i), 1'b0);
        wait_announce(10);
        pop_words(32'h000B_0000, W);
        chk_posy(10, 12'd0);
        repeat (5) @(negedge CLK);
        chk("partial_not_announced", done_cnt, 11);

        // IN_DE while idle is flagged
        IN_DE = 1'b1;
        @(negedge CLK);
        IN_DE = 1'b0;
        chk("de_in_idle_err", ERR, 2'b11);

        // Asynchronous reset mid-drain, then a clean line
        push_line(32'h000C_0000, 1'b0);
        wait_announce(11);
        chk_posy(11, 12'd1);
        pop_words(32'h000C_0000, 800);
        RST_N = 1'b0;
        #1 chk_reset_outputs("mid_drain_reset");
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        push_line(32'h000D_0000, 1'b0);
        wait_announce(12);
        chk_posy(12, 12'd0);
        pop_words(32'h000D_0000, W);
        repeat (5) @(negedge CLK);
        chk("post_reset_one_announce", done_cnt, 13);
        chk("post_reset_err", ERR, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
